// File: rtl/led_pkg.sv
// Shared definitions for the front-panel key path and the led_16 pattern engine.
// Holds the debounce state encoding and the power-on output defaults.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } deb_state_t;

    localparam logic STATE_CTRL_DEFAULT = 1'b0;
    localparam logic SPEED_DEFAULT      = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce FSM and one-cycle
// press/release strobes for an active-low raw key input.
module key_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 26
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press,
    output logic o_release,
    output logic o_held,
    output logic o_idle
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_vld;
    logic             r_armed;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_key;
    logic w_cnt_done;

    assign w_key      = ~r_sync2;
    assign w_cnt_done = (r_cnt >= DEB_LAST);

    // r_vld marks when the synchroniser holds real samples again after reset;
    // r_armed then demands a genuine release so a key held through reset never fires.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && !w_key) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_key && r_armed) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_key) begin
                        r_state <= IDLE;
                    end else if (w_cnt_done) begin
                        r_state <= HELD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_key) begin
                        r_state <= REL_WAIT;
                        r_cnt   <= '0;
                    end
                end
                REL_WAIT: begin
                    if (w_key) begin
                        r_state <= HELD;
                    end else if (w_cnt_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_press   = (r_state == PRESS_WAIT) && w_key && w_cnt_done;
    assign o_release = (r_state == REL_WAIT) && !w_key && w_cnt_done;
    assign o_held    = (r_state == HELD) || (r_state == REL_WAIT);
    assign o_idle    = (r_state == IDLE);

endmodule

// File: rtl/led_key_ctrl.sv
// Front-panel key front end for led_16: MODE short press toggles the pattern,
// MODE long press restores defaults, SPEED press toggles the speed select.
module led_key_ctrl
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int CNT_W             = 26
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_mode_n,
    input  logic i_key_speed_n,
    output logic o_state_ctrl,
    output logic o_speed,
    output logic o_key_evt
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_PRESS_CYCLES);

    logic w_mode_release;
    logic w_mode_held;
    logic w_mode_idle;
    logic w_mode_unused;
    logic w_speed_press;
    logic [2:0] w_speed_unused;
    logic w_long_hit;

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_long_flag;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_mode_deb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_key_n  (i_key_mode_n),
        .o_press  (w_mode_unused),
        .o_release(w_mode_release),
        .o_held   (w_mode_held),
        .o_idle   (w_mode_idle)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_speed_deb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_key_n  (i_key_speed_n),
        .o_press  (w_speed_press),
        .o_release(w_speed_unused[0]),
        .o_held   (w_speed_unused[1]),
        .o_idle   (w_speed_unused[2])
    );

    // The hold counter saturates, so the threshold compare can only match once per press.
    assign w_long_hit = w_mode_held && (r_hold_cnt == LONG_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_cnt   <= '0;
            r_long_flag  <= 1'b0;
            o_state_ctrl <= STATE_CTRL_DEFAULT;
            o_speed      <= SPEED_DEFAULT;
            o_key_evt    <= 1'b0;
        end else begin
            if (!w_mode_held) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt < LONG_MAX) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if (w_mode_idle) begin
                r_long_flag <= 1'b0;
            end else if (w_long_hit) begin
                r_long_flag <= 1'b1;
            end

            // Restore takes priority over any toggle landing in the same cycle.
            o_key_evt <= 1'b0;
            if (w_long_hit) begin
                o_state_ctrl <= STATE_CTRL_DEFAULT;
                o_speed      <= SPEED_DEFAULT;
                o_key_evt    <= 1'b1;
            end else begin
                if (w_mode_release && !r_long_flag) begin
                    o_state_ctrl <= ~o_state_ctrl;
                    o_key_evt    <= 1'b1;
                end
                if (w_speed_press) begin
                    o_speed   <= ~o_speed;
                    o_key_evt <= 1'b1;
                end
            end
        end
    end

endmodule
